// File: rtl/regfile_pkg.sv
// Shared constants and types for the bypassing register file with busy scoreboard.
package regfile_pkg;

  localparam int unsigned REG_WIDTH  = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/register.sv
// n-bit register with synchronous active-high reset and load enable.
module register #(
  parameter int unsigned n = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [n-1:0] d,
  output logic [n-1:0] q
);

  logic [n-1:0] q_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else if (en) begin
      q_q <= d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/regfile_bypass.sv
// Two-read/one-write register file with write-to-read bypass and a per-register
// busy scoreboard tracking issued-but-not-written-back destinations.
module regfile_bypass
  import regfile_pkg::*;
#(
  parameter int unsigned n = REG_WIDTH,
  parameter int unsigned r = REG_ADDR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [r-1:0] ra1,
  input  logic [r-1:0] ra2,
  output logic [n-1:0] rd1,
  output logic [n-1:0] rd2,
  input  logic         we3,
  input  logic [r-1:0] wa3,
  input  logic [n-1:0] wd3,
  input  logic         issue_valid,
  input  logic [r-1:0] issue_rd,
  output logic         busy1,
  output logic         busy2
);

  localparam int unsigned NR = 1 << r;

  logic [n-1:0]  rf [NR];
  logic [NR-1:0] busy_q;
  logic [NR-1:0] busy_d;
  logic          wr_nz;
  logic          byp1;
  logic          byp2;

  assign wr_nz = we3 && (wa3 != '0);
  assign rf[0] = '0;

  // Register 0 has no storage; entries 1..NR-1 are enabled registers.
  for (genvar gi = 1; gi < NR; gi++) begin : g_reg
    register #(.n(n)) u_reg (
      .clk (clk),
      .rst (rst),
      .en  (we3 && (wa3 == r'(gi))),
      .d   (wd3),
      .q   (rf[gi])
    );
  end

  // Issue is applied after writeback so a same-register set wins over the clear.
  always_comb begin
    busy_d = busy_q;
    if (wr_nz) begin
      busy_d[wa3] = 1'b0;
    end
    if (issue_valid && (issue_rd != '0)) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // A value being written this cycle is forwarded and counts as available.
  always_comb begin
    byp1  = wr_nz && (wa3 == ra1);
    byp2  = wr_nz && (wa3 == ra2);
    rd1   = byp1 ? wd3 : rf[ra1];
    rd2   = byp2 ? wd3 : rf[ra2];
    busy1 = busy_q[ra1] && !byp1;
    busy2 = busy_q[ra2] && !byp2;
  end

endmodule
